multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Moore-style control FSM that sequences a shared multicycle RISC-V datapath: one ALU, one unified instruction/data memory and one register file.
It generates per-state mux selects and write strobes for lw, sw, R-type, addi, beq and jal.
Memory accesses use a req/ready handshake with a timeout watchdog.
It sits between the instruction register and the existing ALU decoder, which consumes ALUOp.

Parameters:
WAIT_W, 4, width of the memory wait counter
TIMEOUT, 15, maximum wait cycles for mem_ready before bus_err (must be < 2^WAIT_W)

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
op  input  7  opcode from instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register and OldPC enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  ALU A select: 00=PC, 01=OldPC, 10=rs1
ALUSrcB  output  2  ALU B select: 00=rs2, 01=Imm, 10=constant 4
ALUOp  output  2  00=add, 01=sub/compare, 10=funct-decoded
ImmSrc  output  2  immediate format: 00=I, 01=S, 10=B, 11=J
illegal_op  output  1  one-cycle pulse, unsupported opcode
bus_err  output  1  one-cycle pulse, memory timeout

Behaviour:
- Reset and state register
  - rst_n low: state=FETCH and wait counter=0, both asynchronously.
  - While rst_n is low, PCWrite, IRWrite, RegWrite, MemWrite, mem_req, illegal_op and bus_err are forced to 0.
  - Selects during reset take FETCH values.
  - State encoding is 4-bit: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10.
- Output decoding
  - All outputs are combinational from state, except the strobes gated below.
  - Any output not listed for a state is 0.
  - ImmSrc is decoded from op in every state: 0100011→01, 1100011→10, 1101111→11, else 00.
- FETCH
  - Outputs: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - IRWrite and PCWrite assert only when mem_ready=1.
  - Advances to DECODE on mem_ready=1, otherwise holds.
- DECODE
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00; the branch target is latched into ALUOut.
  - Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other op → FETCH, with illegal_op=1 for this cycle
- MEMADR
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - Next state: lw→MEMREAD, sw→MEMWRITE.
- MEMREAD
  - Outputs: mem_req=1, AdrSrc=1, ResultSrc=00.
  - Advances to MEMWB on mem_ready=1.
- MEMWB
  - Outputs: ResultSrc=01, RegWrite=1.
  - Next state: FETCH.
- MEMWRITE
  - Outputs: mem_req=1, AdrSrc=1, MemWrite=1 (held for the whole wait).
  - Advances to FETCH on mem_ready=1.
- EXECR / EXECI
  - Outputs: ALUSrcA=10, ALUOp=10; ALUSrcB=00 in EXECR, 01 in EXECI.
  - Next state: ALUWB.
- ALUWB
  - Outputs: ResultSrc=00, RegWrite=1.
  - Next state: FETCH.
- BEQ
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero.
  - Next state: FETCH.
- JAL
  - Outputs: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
  - Next state: ALUWB.
- Wait counter and timeout
  - The counter increments on each cycle in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - It clears on any state change, and on a cycle where mem_ready=1 but the state does not change.
  - When counter==TIMEOUT and mem_ready=0: bus_err=1 for one cycle, next state=FETCH, counter cleared, no strobes asserted.
  - A FETCH timeout therefore re-fetches from the same PC.
- Boundary rules
  - mem_ready=1 together with counter==TIMEOUT counts as completion, not an error.
  - mem_ready is ignored in states that do not request memory.
  - Reset asserted mid-access aborts it immediately; no partial strobe may follow reset deassertion.
  - Exactly one state transition per clock.
- Cycle counts per instruction (zero-wait memory): lw 5, sw 4, R-type 4, addi 4, beq 3, jal 4.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - the state enum/localparams
  - ResultSrc/ALUSrcA/ALUSrcB/ALUOp/ImmSrc encodings
- One sub-module, mem_wait_timer (WAIT_W, TIMEOUT): inputs active, ready, clear; output expire.
- ImmSrc and output decode stay inline.

Test Plan:
- Reset: rst_n=0 mid-MEMREAD with mem_ready=0 → state=FETCH immediately, all strobes 0; after release with mem_ready=1, IRWrite=PCWrite=1 in the first cycle.
- lw with zero-wait memory: op=0000011 → states 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01; 5 cycles total.
- sw with 3 wait cycles (mem_ready low for 3 cycles, then high): MemWrite=1 for 4 consecutive cycles, then FETCH; bus_err stays 0.
- beq: zero=1 → PCWrite=1 in BEQ with ALUOp=01 and ALUSrcB=00; zero=0 → PCWrite=0; both return to FETCH after 3 cycles.
- Timeout: mem_ready held 0 in FETCH → bus_err pulses on the 16th waiting cycle, state remains/returns FETCH, IRWrite never asserted.
- Illegal/jal: op=1110011 → illegal_op pulse in DECODE, then FETCH; op=1101111 → ImmSrc=11, PCWrite=1 in JAL, RegWrite=1 in ALUWB.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control FSM: opcodes, states and
// the datapath select codes the controller drives.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Watchdog for memory handshakes: counts stalled cycles while a request is
// outstanding and flags expiry when the stall reaches TIMEOUT.
module mem_wait_timer #(
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ready,
  input  logic clear,
  output logic expire
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT);

  logic [WAIT_W-1:0] count;

  // Completion on the last allowed cycle wins over the timeout.
  assign expire = active && !ready && (count == LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || ready || !active || expire) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a shared multicycle RISC-V datapath (lw, sw, R-type,
// addi, beq, jal) with a req/ready memory handshake and timeout watchdog.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       illegal_op,
  output logic       bus_err
);

  state_t state, state_next;
  logic   expire, mem_active, strobe_ok;
  logic   req_raw, pcw_raw, irw_raw, regw_raw, memw_raw, illegal_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  assign mem_active = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);

  mem_wait_timer #(.WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (mem_active),
    .ready  (mem_ready),
    .clear  (state_next != state),
    .expire (expire)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    req_raw     = 1'b0;
    pcw_raw     = 1'b0;
    irw_raw     = 1'b0;
    regw_raw    = 1'b0;
    memw_raw    = 1'b0;
    illegal_raw = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    ALUOp       = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        req_raw   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (mem_ready) begin
          irw_raw    = 1'b1;
          pcw_raw    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            state_next  = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        req_raw = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        regw_raw   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        req_raw  = 1'b1;
        AdrSrc   = 1'b1;
        memw_raw = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = (state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        ALUOp      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regw_raw   = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_RS1;
        ALUOp      = ALUOP_SUB;
        pcw_raw    = zero;
        state_next = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pcw_raw    = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
    if (expire) state_next = S_FETCH;
  end

  // Strobes are suppressed during reset and on a timeout cycle.
  assign strobe_ok  = rst_n && !expire;
  assign mem_req    = req_raw && rst_n;
  assign PCWrite    = pcw_raw && strobe_ok;
  assign IRWrite    = irw_raw && strobe_ok;
  assign RegWrite   = regw_raw && strobe_ok;
  assign MemWrite   = memw_raw && strobe_ok;
  assign illegal_op = illegal_raw && rst_n;
  assign bus_err    = expire && rst_n;
  assign ImmSrc     = imm_src_of(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed scenarios plus random instruction streams,
// compared cycle by cycle against a phase-sequence reference model.
module tb_multicycle_controller;

  localparam int TO = 15;

  typedef enum {P_FETCH, P_DECODE, P_ADR, P_READ, P_WB, P_WRITE,
                P_EXR, P_EXI, P_ALUWB, P_BEQ, P_JAL} ph_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       zero, mem_ready;
  logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic       illegal_op, bus_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.WAIT_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .illegal_op(illegal_op), .bus_err(bus_err)
  );

  wire [17:0] observed = {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                          ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op, bus_err};

  function automatic logic [17:0] expect_word(input ph_t p, input logic rdy, input logic z,
                                              input logic [6:0] o, input logic to, input logic rst);
    logic req, pcw, adr, memw, irw, regw, ill;
    logic [1:0] res, sa, sb, aop, imm;
    {req, pcw, adr, memw, irw, regw, ill} = '0;
    {res, sa, sb, aop} = '0;
    case (o)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    case (p)
      P_FETCH:  begin req = 1; sb = 2'b10; res = 2'b10; pcw = rdy; irw = rdy; end
      P_DECODE: begin
        sa = 2'b01; sb = 2'b01;
        ill = !(o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111});
      end
      P_ADR:    begin sa = 2'b10; sb = 2'b01; end
      P_READ:   begin req = 1; adr = 1; end
      P_WB:     begin res = 2'b01; regw = 1; end
      P_WRITE:  begin req = 1; adr = 1; memw = !to; end
      P_EXR:    begin sa = 2'b10; aop = 2'b10; end
      P_EXI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      P_ALUWB:  regw = 1;
      P_BEQ:    begin sa = 2'b10; aop = 2'b01; pcw = z; end
      P_JAL:    begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      default:  ;
    endcase
    if (rst) {req, pcw, memw, irw, regw, ill} = '0;
    return {req, pcw, adr, memw, irw, regw, res, sa, sb, aop, imm, ill, to && !rst};
  endfunction

  task automatic compare(input string tag, input logic [17:0] exp);
    checks++;
    assert (observed === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, exp);
    end
  endtask

  // One clock cycle in phase p: drive inputs, check mid-cycle, advance.
  task automatic step(input ph_t p, input logic rdy, input logic z, input logic to);
    mem_ready = rdy;
    zero = z;
    @(negedge clk);
    compare(p.name(), expect_word(p, rdy, z, op, to, 1'b0));
    @(posedge clk);
    #1;
  endtask

  task automatic mem_phase(input ph_t p, input int waits, output bit ok);
    ok = 1'b1;
    for (int k = 0; k <= TO; k++) begin
      if (k >= waits) begin
        step(p, 1'b1, 1'($urandom), 1'b0);
        return;
      end
      if (k == TO) begin
        step(p, 1'b0, 1'($urandom), 1'b1);
        ok = 1'b0;
        return;
      end
      step(p, 1'b0, 1'($urandom), 1'b0);
    end
  endtask

  task automatic run_instr(input logic [6:0] o, input int fw, input int mw, input logic z);
    bit ok;
    int w;
    op = o;
    ok = 1'b0;
    w = fw;
    while (!ok) begin
      mem_phase(P_FETCH, w, ok);
      w = 0;
    end
    step(P_DECODE, 1'($urandom), 1'($urandom), 1'b0);
    case (o)
      7'b0000011: begin
        step(P_ADR, 1'($urandom), 1'($urandom), 1'b0);
        mem_phase(P_READ, mw, ok);
        if (ok) step(P_WB, 1'($urandom), 1'($urandom), 1'b0);
      end
      7'b0100011: begin
        step(P_ADR, 1'($urandom), 1'($urandom), 1'b0);
        mem_phase(P_WRITE, mw, ok);
      end
      7'b0110011: begin step(P_EXR, 1'($urandom), 1'($urandom), 1'b0); step(P_ALUWB, 1'($urandom), 1'($urandom), 1'b0); end
      7'b0010011: begin step(P_EXI, 1'($urandom), 1'($urandom), 1'b0); step(P_ALUWB, 1'($urandom), 1'($urandom), 1'b0); end
      7'b1100011: step(P_BEQ, 1'($urandom), z, 1'b0);
      7'b1101111: begin step(P_JAL, 1'($urandom), 1'($urandom), 1'b0); step(P_ALUWB, 1'($urandom), 1'($urandom), 1'b0); end
      default: ;
    endcase
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 3));
  endfunction

  logic [6:0] legal_ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
  logic [6:0] bad_ops   [4] = '{7'b1110011, 7'b0000000, 7'b1111111, 7'b0010111};

  initial begin
    bit ok;
    rst_n = 1'b0;
    op = 7'b0000011;
    zero = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    compare("reset_idle", expect_word(P_FETCH, 1'b1, 1'b0, op, 1'b0, 1'b1));
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_instr(7'b0000011, 0, 0, 1'b0);      // lw, zero wait: 5 cycles
    run_instr(7'b0100011, 0, 3, 1'b0);      // sw with 3 wait cycles
    run_instr(7'b1100011, 0, 0, 1'b1);      // beq taken
    run_instr(7'b1100011, 0, 0, 1'b0);      // beq not taken
    run_instr(7'b0110011, 15, 0, 1'b0);     // ready on the last allowed cycle
    run_instr(7'b0010011, 16, 0, 1'b0);     // fetch timeout, then re-fetch
    run_instr(7'b0000011, 0, 16, 1'b0);     // data read timeout
    run_instr(7'b0100011, 0, 17, 1'b0);     // data write timeout
    run_instr(7'b1110011, 0, 0, 1'b0);      // illegal opcode
    run_instr(7'b1101111, 0, 0, 1'b0);      // jal

    // Reset in the middle of a stalled data read.
    op = 7'b0000011;
    mem_phase(P_FETCH, 0, ok);
    step(P_DECODE, 1'b0, 1'b0, 1'b0);
    step(P_ADR, 1'b0, 1'b0, 1'b0);
    step(P_READ, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    compare("reset_mid_read", expect_word(P_FETCH, 1'b0, 1'b0, op, 1'b0, 1'b1));
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    compare("reset_held", expect_word(P_FETCH, 1'b1, 1'b0, op, 1'b0, 1'b1));
    rst_n = 1'b1;
    run_instr(7'b0000011, 0, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0)
        run_instr(bad_ops[$urandom_range(0, 3)], rand_wait(), rand_wait(), 1'($urandom));
      else
        run_instr(legal_ops[$urandom_range(0, 5)], rand_wait(), rand_wait(), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

endmodule
